gnr_node_p: RTL and testbench

GNR_NODE_P -- requirements
Module: gnr_node_p

---
 rtl/gnr_pkg.sv | 13 +
 rtl/gnr_node_p_if.sv | 32 +++
 rtl/gnr_sat_cnt.sv | 27 ++
 rtl/gnr_node_p.sv | 110 +++++++++++
 tb/tb_gnr_node_p.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/gnr_pkg.sv
// Shared definitions for the gnr node: FSM encoding and transition-counter sizing.
package gnr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STABLE = 2'd2
    } state_t;

    localparam int          TRANS_W   = 16;
    localparam logic [15:0] TRANS_MAX = 16'hFFFF;

endpackage

// File: rtl/gnr_node_p_if.sv
// Node port bundle. Strobes are single-cycle level samples on the rising clk edge;
// there is no back-pressure, so every qualified strobe is consumed in the cycle it is seen.
interface gnr_node_p_if
    import gnr_pkg::*;
#(
    parameter int W = 1
);
    logic               start;
    logic               reset_nos;
    logic               start_s0;
    logic               start_s1;
    logic [W-1:0]       init_state;
    logic [W-1:0]       next_s0;
    logic [W-1:0]       next_s1;
    logic [W-1:0]       s0;
    logic [W-1:0]       s1;
    logic [W-1:0]       out_s0;
    logic [W-1:0]       out_s1;
    logic               changed;
    logic               stable;
    logic [TRANS_W-1:0] trans_cnt;

    modport master (
        output start, reset_nos, start_s0, start_s1, init_state, next_s0, next_s1,
        input  s0, s1, out_s0, out_s1, changed, stable, trans_cnt
    );

    modport slave (
        input  start, reset_nos, start_s0, start_s1, init_state, next_s0, next_s1,
        output s0, s1, out_s0, out_s1, changed, stable, trans_cnt
    );
endinterface

// File: rtl/gnr_sat_cnt.sv
// Up-counter that sticks at MAX; synchronous clear wins over increment.
module gnr_sat_cnt #(
    parameter int          WIDTH = 8,
    parameter int unsigned MAX   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != MAX_V)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/gnr_node_p.sv
// Two-phase network node: divided s0 update, direct s1 update, change tracking and
// a steady-state detector built on consecutive unchanged s1 updates.
module gnr_node_p
    import gnr_pkg::*;
#(
    parameter int W          = 1,
    parameter int DIV        = 2,
    parameter int STABLE_LIM = 4
) (
    input  logic         clk,
    input  logic         rst,
    gnr_node_p_if.slave  bus,
    output state_t       state_dbg,
    output logic [7:0]   div_cnt_dbg,
    output logic [7:0]   stable_cnt_dbg
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW = $clog2(STABLE_LIM + 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
    localparam logic [SW-1:0] SLIM    = SW'(STABLE_LIM);

    state_t             state_q, state_d;
    logic [W-1:0]       s0_q, s1_q;
    logic [DW-1:0]      div_cnt_q;
    logic               changed_q;
    logic [SW-1:0]      stable_cnt;
    logic [TRANS_W-1:0] trans_cnt;
    logic               q0, q1, s0_load, ch0, ch1, vchg;

    // Strobes are only honoured while enabled, out of IDLE, and not overridden by a reload.
    assign q0      = bus.start && bus.start_s0 && (state_q != ST_IDLE) && !bus.reset_nos;
    assign q1      = bus.start && bus.start_s1 && (state_q != ST_IDLE) && !bus.reset_nos;
    assign s0_load = q0 && (div_cnt_q == DIV_MAX);
    assign ch0     = s0_load && (bus.next_s0 != s0_q);
    assign ch1     = q1 && (bus.next_s1 != s1_q);
    assign vchg    = ch0 || ch1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.reset_nos) state_d = ST_RUN;
            ST_RUN:    if (bus.reset_nos) state_d = ST_RUN;
                       else if (!vchg && (stable_cnt == SLIM)) state_d = ST_STABLE;
            ST_STABLE: if (bus.reset_nos || vchg) state_d = ST_RUN;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_q      <= '0;
            s1_q      <= '0;
            div_cnt_q <= '0;
            changed_q <= 1'b0;
        end else if (bus.reset_nos) begin
            s0_q      <= bus.init_state;
            s1_q      <= bus.init_state;
            div_cnt_q <= DIV_MAX;
            changed_q <= 1'b0;
        end else begin
            if (q0) begin
                if (s0_load) begin
                    s0_q      <= bus.next_s0;
                    div_cnt_q <= '0;
                end else begin
                    div_cnt_q <= div_cnt_q + 1'b1;
                end
            end
            if (q1) s1_q <= bus.next_s1;
            changed_q <= vchg;
        end
    end

    gnr_sat_cnt #(.WIDTH(TRANS_W), .MAX(TRANS_MAX)) u_trans_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.reset_nos),
        .inc (vchg),
        .cnt (trans_cnt)
    );

    // Any change, including an s0 change without start_s1, restarts the steady-state run.
    gnr_sat_cnt #(.WIDTH(SW), .MAX(STABLE_LIM)) u_stable_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.reset_nos || vchg),
        .inc (q1),
        .cnt (stable_cnt)
    );

    assign bus.s0        = s0_q;
    assign bus.s1        = s1_q;
    assign bus.out_s0    = s0_q;
    assign bus.out_s1    = s1_q;
    assign bus.changed   = changed_q;
    assign bus.stable    = (state_q == ST_STABLE);
    assign bus.trans_cnt = trans_cnt;

    assign state_dbg      = state_q;
    assign div_cnt_dbg    = 8'(div_cnt_q);
    assign stable_cnt_dbg = 8'(stable_cnt);
endmodule

// File: tb/tb_gnr_node_p.sv
// Directed bench for gnr_node_p (W=4, DIV=2, STABLE_LIM=4) with hand-computed expectations.
module tb_gnr_node_p;
    import gnr_pkg::*;

    logic       clk;
    logic       rst;
    state_t     state_dbg;
    logic [7:0] div_cnt_dbg;
    logic [7:0] stable_cnt_dbg;
    int         checks;
    int         failures;
    logic [7:0] exp_div [4];

    gnr_node_p_if #(.W(4)) bus ();

    gnr_node_p #(.W(4), .DIV(2), .STABLE_LIM(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .state_dbg      (state_dbg),
        .div_cnt_dbg    (div_cnt_dbg),
        .stable_cnt_dbg (stable_cnt_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change after a falling edge; outputs are sampled at the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_strobes();
        bus.start_s0  = 1'b0;
        bus.start_s1  = 1'b0;
        bus.reset_nos = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_div  = '{8'd0, 8'd1, 8'd0, 8'd1};
        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.reset_nos  = 1'b0;
        bus.start_s0   = 1'b0;
        bus.start_s1   = 1'b0;
        bus.init_state = 4'h0;
        bus.next_s0    = 4'h0;
        bus.next_s1    = 4'h0;
        @(negedge clk);
        @(negedge clk);

        chk("rst_s0", 32'(bus.s0), 32'h0);
        chk("rst_s1", 32'(bus.s1), 32'h0);
        chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("rst_trans", 32'(bus.trans_cnt), 32'h0);
        chk("rst_changed", 32'(bus.changed), 32'h0);
        chk("rst_stable", 32'(bus.stable), 32'h0);
        chk("rst_div", 32'(div_cnt_dbg), 32'h0);

        // Strobes in IDLE are ignored.
        rst = 1'b1;
        bus.start = 1'b1; bus.start_s0 = 1'b1; bus.start_s1 = 1'b1;
        bus.next_s0 = 4'h5; bus.next_s1 = 4'h5;
        step();
        chk("idle_s0", 32'(bus.s0), 32'h0);
        chk("idle_s1", 32'(bus.s1), 32'h0);
        chk("idle_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("idle_trans", 32'(bus.trans_cnt), 32'h0);
        clear_strobes();

        // Divided s0 updates.
        bus.init_state = 4'h1; bus.reset_nos = 1'b1;
        step();
        clear_strobes();
        chk("nos_s0", 32'(bus.s0), 32'h1);
        chk("nos_s1", 32'(bus.s1), 32'h1);
        chk("nos_div", 32'(div_cnt_dbg), 32'h1);
        chk("nos_state", 32'(state_dbg), 32'(ST_RUN));
        bus.next_s0 = 4'h0;
        for (int i = 0; i < 4; i++) begin
            bus.start_s0 = 1'b1;
            step();
            chk($sformatf("div_s0_%0d", i), 32'(bus.s0), 32'h0);
            chk($sformatf("div_cnt_%0d", i), 32'(div_cnt_dbg), 32'(exp_div[i]));
            chk($sformatf("div_changed_%0d", i), 32'(bus.changed), (i == 0) ? 32'h1 : 32'h0);
        end
        clear_strobes();
        chk("div_trans", 32'(bus.trans_cnt), 32'h1);

        // s1 updates every strobe.
        bus.init_state = 4'h3; bus.reset_nos = 1'b1;
        step();
        clear_strobes();
        chk("s1_init", 32'(bus.s1), 32'h3);
        chk("s1_trans_clr", 32'(bus.trans_cnt), 32'h0);
        bus.next_s1 = 4'hA;
        for (int i = 0; i < 3; i++) begin
            bus.start_s1 = 1'b1;
            step();
            chk($sformatf("s1_val_%0d", i), 32'(bus.s1), 32'hA);
            chk($sformatf("s1_changed_%0d", i), 32'(bus.changed), (i == 0) ? 32'h1 : 32'h0);
        end
        clear_strobes();
        chk("s1_trans", 32'(bus.trans_cnt), 32'h1);

        // Steady state after four unchanged s1 updates, broken by an s0 change.
        bus.init_state = 4'hA; bus.reset_nos = 1'b1;
        step();
        clear_strobes();
        bus.next_s1 = 4'hA;
        for (int i = 0; i < 4; i++) begin
            bus.start_s1 = 1'b1;
            step();
        end
        clear_strobes();
        chk("stb_cnt", 32'(stable_cnt_dbg), 32'h4);
        chk("stb_changed", 32'(bus.changed), 32'h0);
        step();
        chk("stb_stable", 32'(bus.stable), 32'h1);
        chk("stb_state", 32'(state_dbg), 32'(ST_STABLE));
        bus.next_s0 = 4'h7; bus.start_s0 = 1'b1;
        step();
        clear_strobes();
        chk("brk_s0", 32'(bus.s0), 32'h7);
        chk("brk_stable", 32'(bus.stable), 32'h0);
        chk("brk_changed", 32'(bus.changed), 32'h1);
        chk("brk_cnt", 32'(stable_cnt_dbg), 32'h0);
        chk("brk_trans", 32'(bus.trans_cnt), 32'h1);

        // Simultaneous s0+s1 change counts once; first strobe only advances the divider.
        bus.start_s0 = 1'b1;
        step();
        chk("sim_pre_s0", 32'(bus.s0), 32'h7);
        chk("sim_pre_div", 32'(div_cnt_dbg), 32'h1);
        bus.next_s0 = 4'h2; bus.next_s1 = 4'h5; bus.start_s1 = 1'b1;
        step();
        clear_strobes();
        chk("sim_s0", 32'(bus.s0), 32'h2);
        chk("sim_s1", 32'(bus.s1), 32'h5);
        chk("sim_trans", 32'(bus.trans_cnt), 32'h2);
        chk("sim_changed", 32'(bus.changed), 32'h1);

        // reset_nos beats a concurrent start_s1.
        bus.init_state = 4'h6; bus.next_s1 = 4'h9;
        bus.reset_nos = 1'b1; bus.start_s1 = 1'b1;
        step();
        bus.reset_nos = 1'b0;
        chk("pri_s1", 32'(bus.s1), 32'h6);
        chk("pri_s0", 32'(bus.s0), 32'h6);
        chk("pri_trans", 32'(bus.trans_cnt), 32'h0);
        chk("pri_changed", 32'(bus.changed), 32'h0);
        chk("pri_div", 32'(div_cnt_dbg), 32'h1);
        chk("pri_stcnt", 32'(stable_cnt_dbg), 32'h0);
        step();
        clear_strobes();
        chk("pri_upd_s1", 32'(bus.s1), 32'h9);
        chk("pri_upd_trans", 32'(bus.trans_cnt), 32'h1);

        // Asynchronous abort mid-run.
        rst = 1'b0;
        #1;
        chk("abort_s0", 32'(bus.s0), 32'h0);
        chk("abort_s1", 32'(bus.s1), 32'h0);
        chk("abort_trans", 32'(bus.trans_cnt), 32'h0);
        chk("abort_changed", 32'(bus.changed), 32'h0);
        chk("abort_state", 32'(state_dbg), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b1;
        bus.next_s0 = 4'hF; bus.next_s1 = 4'hF;
        bus.start_s0 = 1'b1; bus.start_s1 = 1'b1;
        step();
        clear_strobes();
        chk("post_s0", 32'(bus.s0), 32'h0);
        chk("post_s1", 32'(bus.s1), 32'h0);
        chk("post_state", 32'(state_dbg), 32'(ST_IDLE));

        // Transition counter saturation.
        bus.init_state = 4'h0; bus.reset_nos = 1'b1;
        step();
        clear_strobes();
        force dut.u_trans_cnt.cnt_q = 16'hFFFE;
        #1;
        release dut.u_trans_cnt.cnt_q;
        chk("sat_preset", 32'(bus.trans_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            bus.next_s1 = 4'(i + 1);
            bus.start_s1 = 1'b1;
            step();
            chk($sformatf("sat_s1_%0d", i), 32'(bus.s1), 32'(i + 1));
            chk($sformatf("sat_trans_%0d", i), 32'(bus.trans_cnt), 32'hFFFF);
        end
        clear_strobes();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
